// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold controller: FSM state encodings,
// hold-vector constants and hold bit positions used by the pipeline top.
package pipe_hold_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_SNN_WAIT = 2'd2
    } state_e;

    // Bit positions inside hold_flag_o
    localparam int HOLD_PC   = 0;
    localparam int HOLD_IFID = 1;
    localparam int HOLD_IDEX = 2;

    // Hold vectors driven by the controller
    localparam logic [2:0] HOLD_NONE  = 3'b000;
    localparam logic [2:0] HOLD_STALL = 3'b011;
    localparam logic [2:0] HOLD_FLUSH = 3'b110;
    localparam logic [2:0] HOLD_RESET = 3'b111;

    // The flush length is at most 15 cycles, so 4 bits hold the countdown
    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Handshake bundle between the EX stage / accelerator side and the hold
// controller. The controller connects through the master modport; the
// pipeline/accelerator side uses the slave modport.
interface pipe_hold_ctrl_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);

    logic             jump_flag_i;
    logic [DW-1:0]    jump_addr_i;
    logic             mem_stall_i;
    logic             snn_start_i;
    logic             snn_done_i;

    logic [2:0]       hold_flag_o;
    logic             jump_flag_o;
    logic [DW-1:0]    jump_addr_o;
    logic             snn_req_o;
    logic [CNT_W-1:0] snn_cycles_o;
    logic             snn_err_o;

    modport master (
        input  jump_flag_i,
        input  jump_addr_i,
        input  mem_stall_i,
        input  snn_start_i,
        input  snn_done_i,
        output hold_flag_o,
        output jump_flag_o,
        output jump_addr_o,
        output snn_req_o,
        output snn_cycles_o,
        output snn_err_o
    );

    modport slave (
        output jump_flag_i,
        output jump_addr_i,
        output mem_stall_i,
        output snn_start_i,
        output snn_done_i,
        input  hold_flag_o,
        input  jump_flag_o,
        input  jump_addr_o,
        input  snn_req_o,
        input  snn_cycles_o,
        input  snn_err_o
    );

endinterface

// File: rtl/pipe_hold_cnt.sv
// Saturating up/down cycle counter with synchronous load. Load wins over
// increment, increment wins over decrement; it never wraps in either direction.
module pipe_hold_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, saturating increment or saturating decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold controller for the J1/SNN CPU. Generates per-stage
// hold bits, steers jump redirects and runs the req/done handshake with the
// SNN accelerator. Optional watchdog: define PIPE_HOLD_SNN_TIMEOUT_EN to abort
// accelerator jobs that run for TIMEOUT_CYC cycles without a done pulse.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int DW          = 16,
    parameter int FLUSH_CYC   = 1,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hold_ctrl_if.master bus
);

    // The jump cycle is itself the first flush cycle, so FLUSH only needs to
    // cover the remaining FLUSH_CYC-1 cycles.
    localparam bit                     FLUSH_MULTI  = (FLUSH_CYC > 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYC - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic                   snnReq_q;
    logic                   snnReq_d;
    logic [CNT_W-1:0]       snnCycles_q;
    logic [CNT_W-1:0]       snnCycles_d;

    logic                   flushLoad;
    logic                   flushDec;
    logic [FLUSH_CNT_W-1:0] flushCnt;
    logic                   busyLoad;
    logic                   busyInc;
    logic [CNT_W-1:0]       busyCnt;
    logic [CNT_W-1:0]       busyNext;

    logic [2:0]             hold;
    logic                   jumpFlag;
    logic [DW-1:0]          jumpAddr;

`ifdef PIPE_HOLD_SNN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYC);
    logic snnErr_q;
    logic snnErr_d;
`endif

    pipe_hold_cnt #(.W(FLUSH_CNT_W)) u_flush_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (flushLoad),
        .load_val_i (FLUSH_RELOAD),
        .inc_i      (1'b0),
        .dec_i      (flushDec),
        .cnt_o      (flushCnt)
    );

    pipe_hold_cnt #(.W(CNT_W)) u_busy_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (busyLoad),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (busyInc),
        .dec_i      (1'b0),
        .cnt_o      (busyCnt)
    );

    // Job length including the done cycle, saturating at all-ones
    assign busyNext = (busyCnt == '1) ? busyCnt : busyCnt + CNT_W'(1);

    // Next-state, counter control and combinational hold/redirect outputs
    always_comb begin
        state_d     = state_q;
        snnReq_d    = snnReq_q;
        snnCycles_d = snnCycles_q;
        hold        = HOLD_NONE;
        jumpFlag    = 1'b0;
        jumpAddr    = '0;
        flushLoad   = 1'b0;
        flushDec    = 1'b0;
        busyLoad    = 1'b0;
        busyInc     = 1'b0;
`ifdef PIPE_HOLD_SNN_TIMEOUT_EN
        snnErr_d    = snnErr_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (bus.jump_flag_i) begin
                    jumpFlag = 1'b1;
                    jumpAddr = bus.jump_addr_i;
                    hold     = HOLD_FLUSH;
                    if (FLUSH_MULTI) begin
                        flushLoad = 1'b1;
                        state_d   = ST_FLUSH;
                    end
                end else if (bus.snn_start_i) begin
                    hold     = HOLD_STALL;
                    snnReq_d = 1'b1;
                    busyLoad = 1'b1;
                    state_d  = ST_SNN_WAIT;
                end else if (bus.mem_stall_i) begin
                    hold = HOLD_STALL;
                end
            end
            ST_FLUSH: begin
                hold = HOLD_FLUSH;
                if (bus.jump_flag_i) begin
                    jumpFlag  = 1'b1;
                    jumpAddr  = bus.jump_addr_i;
                    flushLoad = 1'b1;
                end else if (flushCnt <= FLUSH_CNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    flushDec = 1'b1;
                end
            end
            ST_SNN_WAIT: begin
                hold    = HOLD_STALL;
                busyInc = 1'b1;
                if (bus.snn_done_i) begin
                    snnReq_d    = 1'b0;
                    snnCycles_d = busyNext;
                    state_d     = ST_RUN;
                end
`ifdef PIPE_HOLD_SNN_TIMEOUT_EN
                else if (busyCnt == TIMEOUT_LAST) begin
                    snnErr_d    = 1'b1;
                    snnReq_d    = 1'b0;
                    snnCycles_d = TIMEOUT_VAL;
                    state_d     = ST_RUN;
                end
`endif
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and handshake registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            snnReq_q    <= 1'b0;
            snnCycles_q <= '0;
        end else begin
            state_q     <= state_d;
            snnReq_q    <= snnReq_d;
            snnCycles_q <= snnCycles_d;
        end
    end

`ifdef PIPE_HOLD_SNN_TIMEOUT_EN
    // Sticky watchdog error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snnErr_q <= 1'b0;
        end else begin
            snnErr_q <= snnErr_d;
        end
    end

    assign bus.snn_err_o = snnErr_q;
`else
    assign bus.snn_err_o = 1'b0;
`endif

    // While reset is low every stage is held and no redirect is issued
    assign bus.hold_flag_o  = rst_n ? hold : HOLD_RESET;
    assign bus.jump_flag_o  = rst_n & jumpFlag;
    assign bus.jump_addr_o  = rst_n ? jumpAddr : '0;
    assign bus.snn_req_o    = snnReq_q;
    assign bus.snn_cycles_o = snnCycles_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed testbench for pipe_hold_ctrl. Two controllers share one stimulus:
// dut3 with FLUSH_CYC=3 and dut1 with FLUSH_CYC=1. Both use TIMEOUT_CYC=20,
// which only matters when PIPE_HOLD_SNN_TIMEOUT_EN is defined.
module tb_pipe_hold_ctrl;

    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    pipe_hold_ctrl_if #(.DW(DW), .CNT_W(CNT_W)) bus3 ();
    pipe_hold_ctrl_if #(.DW(DW), .CNT_W(CNT_W)) bus1 ();

    pipe_hold_ctrl #(.DW(DW), .FLUSH_CYC(3), .CNT_W(CNT_W), .TIMEOUT_CYC(20)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.master)
    );

    pipe_hold_ctrl #(.DW(DW), .FLUSH_CYC(1), .CNT_W(CNT_W), .TIMEOUT_CYC(20)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs to both controllers just after the falling edge
    task automatic applyStimulus(input logic jump, input logic [DW-1:0] addr,
                                 input logic stall, input logic start,
                                 input logic done);
        @(negedge clk);
        bus3.jump_flag_i = jump;
        bus3.jump_addr_i = addr;
        bus3.mem_stall_i = stall;
        bus3.snn_start_i = start;
        bus3.snn_done_i  = done;
        bus1.jump_flag_i = jump;
        bus1.jump_addr_i = addr;
        bus1.mem_stall_i = stall;
        bus1.snn_start_i = start;
        bus1.snn_done_i  = done;
        #1;
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b1;
        bus3.jump_flag_i = 1'b1;
        bus3.jump_addr_i = 16'h0040;
        bus3.mem_stall_i = 1'b0;
        bus3.snn_start_i = 1'b0;
        bus3.snn_done_i  = 1'b0;
        bus1.jump_flag_i = 1'b1;
        bus1.jump_addr_i = 16'h0040;
        bus1.mem_stall_i = 1'b0;
        bus1.snn_start_i = 1'b0;
        bus1.snn_done_i  = 1'b0;

        // Reset asserted mid-cycle, before any rising edge
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_hold", 32'(bus3.hold_flag_o), 32'h7);
        checkOutput("rst_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("rst_jflag", 32'(bus3.jump_flag_o), 32'h0);
        checkOutput("rst_jaddr", 32'(bus3.jump_addr_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("run_hold", 32'(bus3.hold_flag_o), 32'h0);
        checkOutput("run_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("run_cycles", 32'(bus3.snn_cycles_o), 32'h0);
        checkOutput("run_err", 32'(bus3.snn_err_o), 32'h0);

        // Jump: three flush cycles on dut3, one on dut1
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_flag", 32'(bus3.jump_flag_o), 32'h1);
        checkOutput("jmp_addr", 32'(bus3.jump_addr_o), 32'h0040);
        checkOutput("jmp_hold0", 32'(bus3.hold_flag_o), 32'h6);
        checkOutput("jmp1_hold0", 32'(bus1.hold_flag_o), 32'h6);
        checkOutput("jmp1_flag", 32'(bus1.jump_flag_o), 32'h1);
        applyStimulus(1'b0, 16'h0040, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_hold1", 32'(bus3.hold_flag_o), 32'h6);
        checkOutput("jmp_flag1", 32'(bus3.jump_flag_o), 32'h0);
        checkOutput("jmp_addr1", 32'(bus3.jump_addr_o), 32'h0);
        checkOutput("jmp1_hold1", 32'(bus1.hold_flag_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_hold2", 32'(bus3.hold_flag_o), 32'h6);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_hold3", 32'(bus3.hold_flag_o), 32'h0);

        // Jump inside FLUSH reloads the count; stall/start are ignored there
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
        checkOutput("rejmp_flag", 32'(bus3.jump_flag_o), 32'h1);
        checkOutput("rejmp_addr", 32'(bus3.jump_addr_o), 32'h2000);
        checkOutput("rejmp_hold", 32'(bus3.hold_flag_o), 32'h6);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("rejmp_hold1", 32'(bus3.hold_flag_o), 32'h6);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("rejmp_hold2", 32'(bus3.hold_flag_o), 32'h6);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("rejmp_hold3", 32'(bus3.hold_flag_o), 32'h0);
        checkOutput("rejmp_req", 32'(bus3.snn_req_o), 32'h0);

        // Memory stall held for four cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("stall_hold%0d", i), 32'(bus3.hold_flag_o), 32'h3);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_release", 32'(bus3.hold_flag_o), 32'h0);

        // SNN job, done pulse seven cycles after start
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        checkOutput("snn_hold0", 32'(bus3.hold_flag_o), 32'h3);
        checkOutput("snn_req0", 32'(bus3.snn_req_o), 32'h0);
        for (int i = 1; i < 7; i++) begin
            if (i == 3) begin
                applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
                checkOutput("snn_jmp_ignored", 32'(bus3.jump_flag_o), 32'h0);
                checkOutput("snn_jaddr_zero", 32'(bus3.jump_addr_o), 32'h0);
            end else begin
                applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            end
            checkOutput($sformatf("snn_hold%0d", i), 32'(bus3.hold_flag_o), 32'h3);
            checkOutput($sformatf("snn_req%0d", i), 32'(bus3.snn_req_o), 32'h1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("snn_done_hold", 32'(bus3.hold_flag_o), 32'h3);
        checkOutput("snn_done_req", 32'(bus3.snn_req_o), 32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("snn_after_hold", 32'(bus3.hold_flag_o), 32'h0);
        checkOutput("snn_after_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("snn_cycles", 32'(bus3.snn_cycles_o), 32'h7);
        checkOutput("snn_err", 32'(bus3.snn_err_o), 32'h0);

        // Jump and SNN start together: redirect wins, job dropped
        applyStimulus(1'b1, 16'h0080, 1'b0, 1'b1, 1'b0);
        checkOutput("conf_flag", 32'(bus3.jump_flag_o), 32'h1);
        checkOutput("conf_addr", 32'(bus3.jump_addr_o), 32'h0080);
        checkOutput("conf_hold", 32'(bus3.hold_flag_o), 32'h6);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("conf_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("conf_hold1", 32'(bus3.hold_flag_o), 32'h6);
        checkOutput("conf1_req", 32'(bus1.snn_req_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("conf_hold2", 32'(bus3.hold_flag_o), 32'h6);

        // Done pulse while in RUN has no effect
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("stray_done_hold", 32'(bus3.hold_flag_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("stray_done_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("stray_done_cycles", 32'(bus3.snn_cycles_o), 32'h7);
        checkOutput("stray_done_hold1", 32'(bus3.hold_flag_o), 32'h0);

`ifdef PIPE_HOLD_SNN_TIMEOUT_EN
        // Watchdog: start with no done, abort after twenty cycles
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("wd_hold%0d", i), 32'(bus3.hold_flag_o), 32'h3);
            checkOutput($sformatf("wd_req%0d", i), 32'(bus3.snn_req_o), 32'h1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_err", 32'(bus3.snn_err_o), 32'h1);
        checkOutput("wd_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("wd_cycles", 32'(bus3.snn_cycles_o), 32'd20);
        checkOutput("wd_hold", 32'(bus3.hold_flag_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_err_sticky", 32'(bus3.snn_err_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("wd_err_cleared", 32'(bus3.snn_err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Asynchronous reset in the middle of an SNN job
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_req_before", 32'(bus3.snn_req_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_req", 32'(bus3.snn_req_o), 32'h0);
        checkOutput("abort_hold", 32'(bus3.hold_flag_o), 32'h7);
        checkOutput("abort_cycles", 32'(bus3.snn_cycles_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_run_hold", 32'(bus3.hold_flag_o), 32'h0);
        checkOutput("abort_run_req", 32'(bus3.snn_req_o), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
